// File: rtl/key_sched_seq.sv
// key_sched_seq -- sequential AES key expansion (AES-128/192/256).
//
// Expands a cipher key into the full FIPS-197 word schedule, one 32-bit word
// per clock. Round keys are read back combinationally from storage.
//
// Optional feature macro: KEY_SCHED_AES256_EN
//   defined   -> 60 storage words, mode 10 (AES-256) accepted
//   undefined -> 52 storage words, mode 10 rejected like mode 11
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : one-cycle request to expand key_in (ignored while busy)
//   mode    : 00 AES-128, 01 AES-192, 10 AES-256, 11 illegal
//   key_in  : cipher key, left-justified in 256 bits
//   rk_idx  : round-key select 0..Nr
//   rk_out  : selected round key (zero when rk_idx > Nr)
//   busy    : expansion running (EXPAND or DONE)
//   done    : one-cycle pulse when the last word has been written
//   err     : one-cycle pulse on start with an unsupported mode
//
// Timing: counting the start edge as edge 1, done rises on edge 41/47/53.

// Single-byte AES S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = x^-1 (and 0 -> 0): product of x^2, x^4, ..., x^128.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module key_sched_seq #(
  parameter int REV_INDEX = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done,
  output logic         err
);

`ifdef KEY_SCHED_AES256_EN
  localparam int NW = 60;
`else
  localparam int NW = 52;
`endif

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t               state;
  logic [5:0]           cnt;     // index of the word being generated
  logic [2:0]           phase;   // cnt mod Nk, tracked incrementally
  logic [7:0]           rcon;
  logic [1:0]           mode_q;
  logic [NW-1:0][31:0]  w;

  function automatic logic mode_ok(input logic [1:0] m);
`ifdef KEY_SCHED_AES256_EN
    return (m != 2'b11);
`else
    return (m == 2'b00) || (m == 2'b01);
`endif
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd6;
      2'b10:   return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] last_of(input logic [1:0] m);
    case (m)
      2'b01:   return 6'd51;
      2'b10:   return 6'd59;
      default: return 6'd43;
    endcase
  endfunction

  logic [3:0] nk_q;
  logic [3:0] nr_q;
  logic [5:0] last_q;

  assign nk_q   = nk_of(mode_q);
  assign nr_q   = nr_of(mode_q);
  assign last_q = last_of(mode_q);

  // ---------------------------------------------------------------------------
  // Word generator: w[i] = w[i-Nk] ^ f(w[i-1])
  // ---------------------------------------------------------------------------
  logic [31:0] prev, back, sb_in, sb_out, temp, w_new;

  always_comb begin
    prev  = w[cnt - 6'd1];
    back  = w[cnt - {2'b00, nk_q}];
    // RotWord is applied ahead of the S-boxes so one set of four serves both cases.
    sb_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    temp  = prev;
    if (phase == 3'd0)
      temp = sb_out ^ {rcon, 24'h000000};
    else if (nk_q == 4'd8 && phase == 3'd4)
      temp = sb_out;
    w_new = back ^ temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .s(sb_out[8*b +: 8]));
  end

  // ---------------------------------------------------------------------------
  // Round-key read port
  // ---------------------------------------------------------------------------
  logic [3:0] rk_k;
  logic [5:0] rk_base;

  always_comb begin
    rk_k    = (REV_INDEX != 0) ? (nr_q - rk_idx) : rk_idx;
    rk_base = {rk_k, 2'b00};
    rk_out  = '0;
    if (rk_idx <= nr_q)
      rk_out = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
  end

  // ---------------------------------------------------------------------------
  // Control FSM and storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      phase  <= '0;
      rcon   <= 8'h01;
      mode_q <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      w      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode_ok(mode)) begin
              for (int j = 0; j < 8; j++)
                if (j < int'(nk_of(mode))) w[j] <= key_in[255 - 32*j -: 32];
              cnt    <= {2'b00, nk_of(mode)};
              phase  <= 3'd0;
              rcon   <= 8'h01;
              mode_q <= mode;
              busy   <= 1'b1;
              state  <= EXPAND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXPAND: begin
          w[cnt] <= w_new;
          phase  <= (phase == 3'(nk_q - 4'd1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0)
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (cnt == last_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sched_seq.sv
// Directed bench for key_sched_seq with a queue-based scoreboard.
// Two instances share all inputs: one with forward and one with reverse
// round-key indexing. Expected values are FIPS-197 key-schedule vectors.
module tb_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk0, rk1;
  logic         busy0, done0, err0, busy1, done1, err1;

  always #5 clk = ~clk;

  key_sched_seq #(.REV_INDEX(0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .rk_idx(rk_idx), .rk_out(rk0), .busy(busy0), .done(done0), .err(err0));

  key_sched_seq #(.REV_INDEX(1)) dut_rev (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .rk_idx(rk_idx), .rk_out(rk1), .busy(busy1), .done(done1), .err(err1));

  localparam logic [255:0] K128     = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K192     = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] RK192_0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK192_1  = 128'h10111213141516175846f2f95c43f4fe;
  localparam logic [127:0] RK192_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [255:0] K256     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
`ifdef KEY_SCHED_AES256_EN
  localparam logic [127:0] RK256_0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK256_2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] RK256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
`endif

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_val(input string tag, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [127:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start across one edge, then wait (bounded) for done.
  // Latency counts the start edge as 1.
  task automatic run_start(input logic [1:0] m, input logic [255:0] k, output int lat);
    mode   = m;
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 1;
    while (!done0 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx);
    rk_idx = idx;
    #1;
  endtask

  int lat;
  int n_done;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 2'b00;
    key_in = '0;
    rk_idx = 4'd0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    expect_val("reset_status", 128'h0);
    check(128'({busy0, done0, err0, busy1, done1, err1}));
    expect_val("reset_rk", 128'h0);
    check(rk0);
    rst = 1'b0;
    tick();

    // ---- AES-128
    run_start(2'b00, K128, lat);
    expect_val("aes128_latency", 128'd41);
    check(128'(lat));
    expect_val("aes128_done_busy", 128'b11_11);
    check(128'({busy0, done0, busy1, done1}));
    tick();
    expect_val("aes128_after_done", 128'h0);
    check(128'({busy0, done0}));
    read_rk(4'd0);
    expect_val("aes128_rk0", RK128_0);
    check(rk0);
    expect_val("aes128_rev_rk0", RK128_10);
    check(rk1);
    read_rk(4'd1);
    expect_val("aes128_rk1", RK128_1);
    check(rk0);
    read_rk(4'd10);
    expect_val("aes128_rk10", RK128_10);
    check(rk0);
    expect_val("aes128_rev_rk10", RK128_0);
    check(rk1);
    read_rk(4'd11);
    expect_val("aes128_rk11_zero", 128'h0);
    check(rk0);
    read_rk(4'd15);
    expect_val("aes128_rev_rk15_zero", 128'h0);
    check(rk1);

    // ---- AES-192
    run_start(2'b01, K192, lat);
    expect_val("aes192_latency", 128'd47);
    check(128'(lat));
    tick();
    read_rk(4'd0);
    expect_val("aes192_rk0", RK192_0);
    check(rk0);
    expect_val("aes192_rev_rk0", RK192_12);
    check(rk1);
    read_rk(4'd1);
    expect_val("aes192_rk1", RK192_1);
    check(rk0);
    read_rk(4'd12);
    expect_val("aes192_rk12", RK192_12);
    check(rk0);
    read_rk(4'd13);
    expect_val("aes192_rk13_zero", 128'h0);
    check(rk0);

    // ---- illegal mode 11: err pulse, storage untouched
    read_rk(4'd12);
    mode   = 2'b11;
    key_in = K128;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    expect_val("mode11_err", 128'b01);
    check(128'({busy0, err0}));
    tick();
    expect_val("mode11_err_clear", 128'h0);
    check(128'({busy0, err0, done0}));
    expect_val("mode11_rk_kept", RK192_12);
    check(rk0);

`ifdef KEY_SCHED_AES256_EN
    // ---- AES-256
    run_start(2'b10, K256, lat);
    expect_val("aes256_latency", 128'd53);
    check(128'(lat));
    tick();
    read_rk(4'd0);
    expect_val("aes256_rk0", RK256_0);
    check(rk0);
    expect_val("aes256_rev_rk0", RK256_14);
    check(rk1);
    read_rk(4'd2);
    expect_val("aes256_rk2", RK256_2);
    check(rk0);
    read_rk(4'd14);
    expect_val("aes256_rk14", RK256_14);
    check(rk0);
`else
    // ---- mode 10 without AES-256 support: same as illegal
    mode   = 2'b10;
    key_in = K256;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    expect_val("mode10_err", 128'b01);
    check(128'({busy0, err0}));
    tick();
    expect_val("mode10_err_clear", 128'h0);
    check(128'({busy0, err0}));
    expect_val("mode10_rk_kept", RK192_12);
    check(rk0);
`endif

    // ---- second start during EXPAND is ignored
    mode   = 2'b00;
    key_in = K128;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 1;
    repeat (9) begin tick(); lat++; end
    mode   = 2'b01;
    key_in = K192;
    start  = 1'b1;
    tick();
    lat++;
    start  = 1'b0;
    while (!done0 && lat < 200) begin tick(); lat++; end
    expect_val("restart_ignored_latency", 128'd41);
    check(128'(lat));
    tick();
    read_rk(4'd10);
    expect_val("restart_ignored_rk10", RK128_10);
    check(rk0);
    read_rk(4'd0);
    expect_val("restart_ignored_rk0", RK128_0);
    check(rk0);

    // ---- reset mid-EXPAND: immediate clear, no done
    read_rk(4'd10);
    mode   = 2'b00;
    key_in = K128;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    #1;
    expect_val("midrst_status", 128'h0);
    check(128'({busy0, done0, err0}));
    expect_val("midrst_rk", 128'h0);
    check(rk0);
    n_done = 0;
    repeat (2) begin tick(); if (done0) n_done++; end
    rst = 1'b0;
    repeat (60) begin tick(); if (done0) n_done++; end
    expect_val("midrst_no_done", 128'h0);
    check(128'(n_done));

    // ---- fresh start after reset behaves as from power-up
    run_start(2'b00, K128, lat);
    expect_val("postrst_latency", 128'd41);
    check(128'(lat));
    tick();
    read_rk(4'd10);
    expect_val("postrst_rk10", RK128_10);
    check(rk0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
